// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl: parses debug commands from a UART RX byte stream, runs
// OBI reads/writes on one manager port, and answers on the UART TX stream.
module uart_debug_ctrl #(
    parameter int unsigned TimeoutCycles = 100000,
    parameter logic [7:0]  CmdRead       = 8'h11,
    parameter logic [7:0]  CmdWrite      = 8'h12,
    parameter logic [7:0]  CmdExec       = 8'h13,
    parameter logic [7:0]  AckByte       = 8'h06,
    parameter logic [7:0]  EotByte       = 8'h04,
    parameter logic [7:0]  NakByte       = 8'h15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,
    output logic [31:0] boot_addr_o,
    output logic        fetch_en_o,
    output logic        busy_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_LEN, S_WR_DATA, S_BUS_REQ, S_BUS_WAIT,
        S_TX_ACK, S_TX_DATA, S_TX_EOT, S_TX_NAK, S_EXEC
    } state_e;

    typedef enum logic [1:0] {CMD_READ, CMD_WRITE, CMD_EXEC} cmd_e;

    localparam logic [31:0] TmoLast = 32'(TimeoutCycles - 1);

    state_e      state_q, state_d, resp_state;
    cmd_e        cmd_q;
    logic [31:0] addr_q, wdata_q, rdata_q, tmo_q, boot_addr_q;
    logic [8:0]  words_q;
    logic [1:0]  byte_q;
    logic        err_q, fetch_en_q;
    logic        rx_fire, tx_fire, resp, last_word, tmo_state, tmo_hit;

    assign rx_fire   = rx_valid_i & rx_ready_o;
    assign tx_fire   = tx_valid_o & tx_ready_i;
    assign resp      = obi_rvalid_i & ((state_q == S_BUS_WAIT) |
                                       ((state_q == S_BUS_REQ) & obi_gnt_i));
    assign last_word = (words_q == 9'd1);
    assign tmo_state = state_q inside {S_ADDR, S_LEN, S_WR_DATA};
    assign tmo_hit   = (TimeoutCycles != 0) && tmo_state && !rx_fire && (tmo_q == TmoLast);

    assign obi_addr_o  = addr_q;
    assign obi_wdata_o = wdata_q;
    assign obi_we_o    = obi_req_o && (cmd_q == CMD_WRITE);
    assign obi_be_o    = obi_req_o ? 4'hF : 4'h0;
    assign boot_addr_o = boot_addr_q;
    assign fetch_en_o  = fetch_en_q;
    assign busy_o      = (state_q != S_IDLE);

    // State register; async reset drops any command or bus transaction in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and handshake outputs; a bus error skips the remaining words
    always_comb begin
        state_d    = state_q;
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        obi_req_o  = 1'b0;
        resp_state = S_TX_DATA;
        if (cmd_q == CMD_WRITE) begin
            if (obi_err_i) resp_state = last_word ? S_TX_NAK : S_WR_DATA;
            else           resp_state = last_word ? S_TX_ACK : S_WR_DATA;
        end else if (obi_err_i) begin
            resp_state = S_TX_NAK;
        end
        case (state_q)
            S_IDLE: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i && ((rx_data_i == CmdRead) || (rx_data_i == CmdWrite) ||
                                   (rx_data_i == CmdExec)))
                    state_d = S_ADDR;
            end
            S_ADDR: begin
                rx_ready_o = 1'b1;
                if (rx_fire && byte_q == 2'd3)
                    state_d = (cmd_q == CMD_EXEC) ? S_EXEC : S_LEN;
            end
            S_LEN: begin
                rx_ready_o = 1'b1;
                if (rx_fire) state_d = (cmd_q == CMD_WRITE) ? S_WR_DATA : S_TX_ACK;
            end
            S_WR_DATA: begin
                rx_ready_o = 1'b1;
                if (rx_fire && byte_q == 2'd3) begin
                    if (err_q) state_d = last_word ? S_TX_NAK : S_WR_DATA;
                    else       state_d = S_BUS_REQ;
                end
            end
            S_BUS_REQ: begin
                obi_req_o = 1'b1;
                if (obi_gnt_i) state_d = resp ? resp_state : S_BUS_WAIT;
            end
            S_BUS_WAIT: begin
                if (obi_rvalid_i) state_d = resp_state;
            end
            S_TX_ACK: begin
                tx_valid_o = 1'b1;
                tx_data_o  = AckByte;
                if (tx_ready_i) state_d = (cmd_q == CMD_READ) ? S_BUS_REQ : S_IDLE;
            end
            S_TX_DATA: begin
                tx_valid_o = 1'b1;
                tx_data_o  = rdata_q[{byte_q, 3'b000} +: 8];
                if (tx_ready_i && byte_q == 2'd3)
                    state_d = last_word ? S_TX_EOT : S_BUS_REQ;
            end
            S_TX_EOT: begin
                tx_valid_o = 1'b1;
                tx_data_o  = EotByte;
                if (tx_ready_i) state_d = S_IDLE;
            end
            S_TX_NAK: begin
                tx_valid_o = 1'b1;
                tx_data_o  = NakByte;
                if (tx_ready_i) state_d = S_IDLE;
            end
            S_EXEC:  state_d = S_TX_ACK;
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) state_d = S_IDLE;
    end

    // Command datapath: address/data assembly, word counting, boot control
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q       <= CMD_READ;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            words_q     <= 9'd0;
            byte_q      <= 2'd0;
            err_q       <= 1'b0;
            boot_addr_q <= 32'h0;
            fetch_en_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    byte_q <= 2'd0;
                    err_q  <= 1'b0;
                    if (rx_fire) begin
                        if (rx_data_i == CmdRead)       cmd_q <= CMD_READ;
                        else if (rx_data_i == CmdWrite) cmd_q <= CMD_WRITE;
                        else if (rx_data_i == CmdExec)  cmd_q <= CMD_EXEC;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        if (byte_q == 2'd0) addr_q[7:0] <= rx_data_i & 8'hFC;
                        else                addr_q[{byte_q, 3'b000} +: 8] <= rx_data_i;
                        byte_q <= byte_q + 2'd1;
                    end
                end
                S_LEN: begin
                    if (rx_fire) words_q <= (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};
                end
                S_WR_DATA: begin
                    if (rx_fire) begin
                        wdata_q[{byte_q, 3'b000} +: 8] <= rx_data_i;
                        byte_q <= byte_q + 2'd1;
                        if (byte_q == 2'd3 && err_q) words_q <= words_q - 9'd1;
                    end
                end
                S_BUS_REQ, S_BUS_WAIT: begin
                    if (resp) begin
                        addr_q <= addr_q + 32'd4;
                        if (obi_err_i) err_q <= 1'b1;
                        if (cmd_q == CMD_WRITE) words_q <= words_q - 9'd1;
                        else                    rdata_q <= obi_rdata_i;
                    end
                end
                S_TX_DATA: begin
                    if (tx_fire) begin
                        byte_q <= byte_q + 2'd1;
                        if (byte_q == 2'd3) words_q <= words_q - 9'd1;
                    end
                end
                S_EXEC: begin
                    boot_addr_q <= addr_q;
                    fetch_en_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Inter-byte timeout, restarted by every accepted byte of a command
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                   tmo_q <= 32'h0;
        else if (tmo_state && !rx_fire) tmo_q <= tmo_q + 32'd1;
        else                           tmo_q <= 32'h0;
    end

endmodule
